// File: rtl/accel_pickoff_encoder.sv
// Simulation-side accelerometer pickoff source: emits a signed command as two-phase
// Gray-coded quadrature steps at a programmable rate and tracks the net position.
module accel_pickoff_encoder #(
    parameter int unsigned CW       = 12,
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned PW       = 16
) (
    input  logic          SIM_CLK,
    input  logic          SIM_RST,
    input  logic          CMD_VALID,
    input  logic [CW-1:0] CMD_COUNT,
    output logic          CMD_READY,
    input  logic          HOLD,
    output logic          PHA,
    output logic          PHB,
    output logic          DIR,
    output logic          BUSY,
    output logic          DONE,
    output logic [PW-1:0] POS
);

    localparam int unsigned TW = $clog2(STEP_DIV);
    localparam logic [TW-1:0] TimerReload = TW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e        state_q;
    logic [1:0]    ph_q;          // {PHB, PHA}
    logic          dir_q;
    logic          busy_q;
    logic          done_q;
    logic [PW-1:0] pos_q;
    logic [CW-1:0] remaining_q;
    logic [TW-1:0] timer_q;

    logic [1:0]    ph_bin;
    logic [1:0]    ph_bin_step;
    logic [1:0]    ph_d;
    logic [PW-1:0] pos_d;
    logic [CW-1:0] cmd_mag;

    // Step the phase through its binary index so both directions share one path.
    always_comb begin
        ph_bin      = {ph_q[1], ph_q[1] ^ ph_q[0]};
        ph_bin_step = dir_q ? (ph_bin - 2'd1) : (ph_bin + 2'd1);
        ph_d        = ph_bin_step ^ {1'b0, ph_bin_step[1]};
        pos_d       = dir_q ? (pos_q - PW'(1)) : (pos_q + PW'(1));
        // Most-negative count maps to 2^(CW-1) as an unsigned magnitude.
        cmd_mag     = CMD_COUNT[CW-1] ? (~CMD_COUNT + CW'(1)) : CMD_COUNT;
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q     <= StIdle;
            ph_q        <= 2'b00;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pos_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (CMD_VALID) begin
                        if (CMD_COUNT != '0) begin
                            remaining_q <= cmd_mag;
                            dir_q       <= CMD_COUNT[CW-1];
                            timer_q     <= TimerReload;
                            busy_q      <= 1'b1;
                            state_q     <= StRun;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end
                    end
                end
                StRun: begin
                    if (!HOLD) begin
                        if (timer_q != '0) begin
                            timer_q <= timer_q - TW'(1);
                        end else begin
                            ph_q        <= ph_d;
                            pos_q       <= pos_d;
                            remaining_q <= remaining_q - CW'(1);
                            timer_q     <= TimerReload;
                            if (remaining_q == CW'(1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StFin;
                            end
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign CMD_READY = (state_q == StIdle);
    assign PHA       = ph_q[0];
    assign PHB       = ph_q[1];
    assign DIR       = dir_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign POS       = pos_q;

endmodule
